mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle control unit for the ARM-subset datapath. It replaces the single-cycle decode/condition path with a state machine that sequences one instruction over 3–5 cycles through a shared ALU and a unified instruction/data memory.
- It holds the architectural NZCV flags and evaluates the condition field.
- It stalls on a memory-ready handshake.
- It drives all datapath mux selects, write enables and byte enables.

Parameters:
- NOP_ON_UNSUPPORTED, 1, unsupported data-processing cmd executes as NOP (no register or flag write) rather than ADD.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- Instr  in  27 [31:5]  instruction register contents
- ALUFlags  in  4  {N,Z,C,V} from the ALU, this cycle
- AdrLow  in  2  ALUResult[1:0], byte address offset
- MemReady  in  1  memory completed the access this cycle
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- IRWrite  out  1  instruction register load
- MemWrite  out  1  memory store strobe
- be  out  4  store byte enables
- RegWrite  out  1  register-file write
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=ExtImm/shifted reg, 01=ExtImm, 10=const 4
- ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 EOR
- ImmSrc  out  2  = Instr[27:26]
- RegSrc  out  2  {Instr[26]&~Instr[20], Instr[27]}

Behaviour:
States and Op = Instr[27:26]:
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - PCWrite and IRWrite are gated by MemReady; stay in FETCH until MemReady=1, then go to DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 for R15 reads).
  - CondEx=0 → FETCH, with no side effects.
  - Op=00 → EXECUTE.
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=11 → FETCH (undefined = NOP).
- EXECUTE: ALUSrcA=0; ALUSrcB = Instr[25] ? 01 : 00; ALUControl from cmd=Instr[24:21]:
  - 0100→ADD, 0010→SUB, 0000→AND, 1100→ORR, 0001→EOR, 1010 (CMP)→SUB.
  - Next state ALUWB, except CMP → FETCH.
  - If Instr[20]=1: latch N,Z from ALUFlags at the clock edge ending EXECUTE. C,V are latched only for ADD/SUB/CMP.
- ALUWB: ResultSrc=00, RegWrite=1 (0 for unsupported cmd when NOP_ON_UNSUPPORTED=1), then FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl = Instr[23] ? ADD : SUB.
  - Instr[20]=1 → MEMREAD; else → MEMWRITE.
- MEMREAD: AdrSrc=1; hold until MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1; hold until MemReady, then FETCH.
  - be = 1111 when Instr[22]=0; else 0001<<AdrLow.
  - be=0000 in every state except MEMWRITE.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=1, then FETCH.

Condition:
- CondEx is evaluated combinationally from Instr[31:28] and the registered flags using the ARM EQ..AL table.
- 1111 is treated as never.

Timing:
- Cycles assuming MemReady=1: DP = 4, CMP = 3, LDR = 5, STR = 4, B = 3, failed condition = 2.

Reset:
- Async, active-high: state←FETCH, flags←0000.
- While reset=1, all write enables (PCWrite, IRWrite, RegWrite, MemWrite) and be are forced to 0. The remaining selects take their FETCH values.
- Reset asserted in any state (including mid-MEMWRITE) aborts the state immediately; no partial write is issued after reset rises.

Boundary conditions:
- MemReady is ignored outside FETCH, MEMREAD and MEMWRITE.
- Flags never change outside the EXECUTE exit edge.
- Once the state has left DECODE, a flag update does not retroactively change CondEx for the current instruction.

Test Plan:
- Reset mid-MEMWRITE, then release → state FETCH, flags 0000, MemWrite=0 and be=0000 during reset; first FETCH asserts IRWrite.
- ADDS R1,R2,#5 (E2921005) with ALUFlags=0100 at EXECUTE → states FETCH, DECODE, EXECUTE, ALUWB; RegWrite=1 in ALUWB only; flags become Z=1.
- CMP (E1520003) then BEQ (0A000002) with Z=1 → CMP takes 3 cycles with no RegWrite; BRANCH asserts PCWrite. Repeat with ALUFlags=0000 → BEQ returns FETCH from DECODE with no PCWrite.
- LDR (E5921004) with MemReady low for 2 cycles in MEMREAD → holds MEMREAD 3 cycles, then MEMWB with ResultSrc=01, RegWrite=1.
- STRB (E5C21001) with AdrLow=10 → MEMWRITE asserts MemWrite=1, be=0100. STR word → be=1111.
- FETCH with MemReady=0 for 3 cycles → PCWrite=IRWrite=0 until MemReady=1; then PCWrite and IRWrite are asserted together for exactly one cycle.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle control FSM for the ARM-subset datapath: sequences fetch/decode/execute
// through a shared ALU and unified memory, holds NZCV and evaluates the condition field.
module mc_controller #(
    parameter bit NOP_ON_UNSUPPORTED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:5] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic [1:0]  AdrLow,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic [3:0]  be,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_ALUWB, S_MEMADR,
        S_MEMREAD, S_MEMWB, S_MEMWRITE, S_BRANCH
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_EOR = 4'b0100;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;   // {N,Z,C,V}
    logic       cond_ex;
    logic [3:0] dp_alu;
    logic       dp_ok, dp_arith, dp_wr, is_cmp;
    logic       n_f, z_f, c_f, v_f;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^Instr[19:5];
    assign {n_f, z_f, c_f, v_f} = flags_q;
    assign ImmSrc = Instr[27:26];
    assign RegSrc = {Instr[26] & ~Instr[20], Instr[27]};
    assign is_cmp = (Instr[24:21] == 4'b1010);
    // Unsupported commands either vanish (no writes) or behave exactly like ADD.
    assign dp_wr  = dp_ok | ~NOP_ON_UNSUPPORTED;

    always_comb begin
        dp_ok    = 1'b1;
        dp_arith = 1'b0;
        dp_alu   = ALU_ADD;
        case (Instr[24:21])
            4'b0100: begin dp_alu = ALU_ADD; dp_arith = 1'b1; end
            4'b0010: begin dp_alu = ALU_SUB; dp_arith = 1'b1; end
            4'b1010: begin dp_alu = ALU_SUB; dp_arith = 1'b1; end
            4'b0000: dp_alu = ALU_AND;
            4'b1100: dp_alu = ALU_ORR;
            4'b0001: dp_alu = ALU_EOR;
            default: begin dp_ok = 1'b0; dp_arith = 1'b1; end
        endcase
    end

    always_comb begin
        cond_ex = 1'b0;
        case (Instr[31:28])
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        be         = '0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b10;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                IRWrite = MemReady;
                PCWrite = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (!cond_ex) state_d = S_FETCH;
                else begin
                    case (Instr[27:26])
                        2'b00:   state_d = S_EXECUTE;
                        2'b01:   state_d = S_MEMADR;
                        2'b10:   state_d = S_BRANCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b0;
                ALUSrcB    = Instr[25] ? 2'b01 : 2'b00;
                ALUControl = dp_alu;
                state_d    = is_cmp ? S_FETCH : S_ALUWB;
                if (Instr[20] && dp_wr) begin
                    flags_d[3:2] = ALUFlags[3:2];
                    if (dp_arith) flags_d[1:0] = ALUFlags[1:0];
                end
            end
            S_ALUWB: begin
                ResultSrc = 2'b00;
                RegWrite  = dp_wr;
                state_d   = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b0;
                ALUSrcB    = 2'b01;
                ALUControl = Instr[23] ? ALU_ADD : ALU_SUB;
                state_d    = Instr[20] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                be       = Instr[22] ? (4'b0001 << AdrLow) : 4'b1111;
                if (MemReady) state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b0;
                ALUSrcB = 2'b01;
                PCWrite = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // State is already FETCH under reset; only the strobes need suppressing.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            be       = '0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus a randomized
// instruction stream checked against an instruction-level reference model.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:5] Instr;
    logic [3:0]  ALUFlags;
    logic [1:0]  AdrLow;
    logic        MemReady;
    logic        PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUSrcA;
    logic [3:0]  be, ALUControl;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;

    mc_controller #(.NOP_ON_UNSUPPORTED(1'b1)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .AdrLow(AdrLow),
        .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .be(be), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] FETCH_SEL = 10'b0_1_10_0000_10;

    int tests = 0;
    int fails = 0;

    // Architectural flag model
    bit mN, mZ, mC, mV;

    bit         ff_en;
    logic [3:0] ff_val;
    bit         fa_en;
    logic [1:0] fa_val;

    int         obs_len, obs_stall_bad, obs_pc_cnt, obs_pc_k, obs_rw_cnt, obs_rw_k;
    int         obs_mw_cnt, obs_be_bad, obs_static_bad;
    logic       obs_f_pc, obs_f_ir, obs_mw_adrsrc, obs_srca2;
    logic [9:0] obs_f_sel;
    logic [1:0] obs_rw_src, obs_srcb2, obs_be_adr;
    logic [3:0] obs_be, obs_alu2, obs_exflags;

    int         e_len, e_rw, e_rw_k, e_pc, e_mw;
    bit         e_mem, e_chk2, e_chk_alu, e_pass;
    logic [1:0] e_rw_src, e_srcb;
    logic [3:0] e_alu;

    function automatic bit cond_holds(input logic [3:0] cc);
        case (cc)
            4'h0: return mZ;
            4'h1: return !mZ;
            4'h2: return mC;
            4'h3: return !mC;
            4'h4: return mN;
            4'h5: return !mN;
            4'h6: return mV;
            4'h7: return !mV;
            4'h8: return mC && !mZ;
            4'h9: return !mC || mZ;
            4'hA: return mN == mV;
            4'hB: return mN != mV;
            4'hC: return !mZ && (mN == mV);
            4'hD: return mZ || (mN != mV);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic predict(input logic [31:0] ins);
        logic [3:0] cmd;
        cmd = ins[24:21];
        e_pass = cond_holds(ins[31:28]);
        e_len = 2; e_rw = 0; e_rw_k = -1; e_rw_src = 2'b00; e_pc = 0; e_mw = 0;
        e_mem = 0; e_chk2 = 0; e_chk_alu = 0; e_alu = 4'h0; e_srcb = 2'b00;
        if (e_pass) begin
            case (ins[27:26])
                2'b00: begin
                    e_chk2 = 1; e_chk_alu = 1;
                    e_srcb = ins[25] ? 2'b01 : 2'b00;
                    case (cmd)
                        4'b0010, 4'b1010: e_alu = 4'h1;
                        4'b0000: e_alu = 4'h2;
                        4'b1100: e_alu = 4'h3;
                        4'b0001: e_alu = 4'h4;
                        default: e_alu = 4'h0;
                    endcase
                    if (cmd == 4'b1010) e_len = 3;
                    else begin
                        e_len = 4;
                        e_rw = (cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001}) ? 1 : 0;
                        e_rw_k = 3;
                    end
                end
                2'b01: begin
                    e_chk2 = 1; e_chk_alu = 1; e_mem = 1; e_srcb = 2'b01;
                    e_alu = ins[23] ? 4'h0 : 4'h1;
                    if (ins[20]) begin e_len = 5; e_rw = 1; e_rw_k = 4; e_rw_src = 2'b01; end
                    else begin e_len = 4; e_mw = 1; end
                end
                2'b10: begin e_chk2 = 1; e_srcb = 2'b01; e_len = 3; e_pc = 1; end
                default: e_len = 2;
            endcase
        end
    endtask

    task automatic model_update(input logic [31:0] ins);
        logic [3:0] cmd;
        cmd = ins[24:21];
        if (e_pass && ins[27:26] == 2'b00 && ins[20] &&
            (cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010})) begin
            mN = obs_exflags[3]; mZ = obs_exflags[2];
            if (cmd inside {4'b0100, 4'b0010, 4'b1010}) begin
                mC = obs_exflags[1]; mV = obs_exflags[0];
            end
        end
    endtask

    // Drives one instruction starting at its FETCH cycle and records what the DUT did.
    // Returns with the next FETCH cycle driven but not yet clocked.
    task automatic exec_instr(input logic [31:5] iw, input int fs, input int ms,
                              input int base_len, input bit is_mem);
        int total;
        total = base_len + ms;
        obs_len = -1; obs_stall_bad = 0; obs_pc_cnt = 0; obs_pc_k = -1; obs_rw_cnt = 0;
        obs_rw_k = -1; obs_mw_cnt = 0; obs_be_bad = 0; obs_static_bad = 0;
        obs_f_pc = 0; obs_f_ir = 0; obs_f_sel = '0; obs_mw_adrsrc = 0; obs_srca2 = 1'bx;
        obs_rw_src = 2'bxx; obs_srcb2 = 2'bxx; obs_be_adr = 0; obs_be = 4'hx; obs_alu2 = 4'hx;
        obs_exflags = 4'h0;
        for (int c = 0; c < fs + total + 20; c++) begin
            int k;
            k = c - fs;
            Instr    = iw;
            ALUFlags = (ff_en && k == 2) ? ff_val : 4'($urandom);
            AdrLow   = fa_en ? fa_val : 2'($urandom);
            if (k < 0) MemReady = 1'b0;
            else if (k == 0 || k >= total) MemReady = 1'b1;
            else if (is_mem && k >= 3 && k < 3 + ms) MemReady = 1'b0;
            else if (is_mem && k == 3 + ms) MemReady = 1'b1;
            else MemReady = 1'($urandom);
            if (k == 2) obs_exflags = ALUFlags;
            #1;
            if (k > 0 && IRWrite) begin obs_len = k; return; end
            if (k < 0 && (PCWrite || IRWrite)) obs_stall_bad++;
            if (k == 0) begin
                obs_f_pc = PCWrite; obs_f_ir = IRWrite;
                obs_f_sel = {AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc};
            end
            if (k >= 1 && PCWrite) begin obs_pc_cnt++; obs_pc_k = k; end
            if (RegWrite) begin obs_rw_cnt++; obs_rw_k = k; obs_rw_src = ResultSrc; end
            if (MemWrite) begin
                obs_mw_cnt++; obs_be = be; obs_be_adr = AdrLow; obs_mw_adrsrc = AdrSrc;
            end else if (be !== 4'h0) obs_be_bad++;
            if (k == 2) begin obs_alu2 = ALUControl; obs_srca2 = ALUSrcA; obs_srcb2 = ALUSrcB; end
            if ({ImmSrc, RegSrc} !== {iw[27:26], iw[26] & ~iw[20], iw[27]}) obs_static_bad++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] ins;
        reset = 1'b1; Instr = '0; ALUFlags = 4'h0; AdrLow = 2'b00; MemReady = 1'b1;
        ff_en = 0; fa_en = 0;
        @(negedge clk); @(negedge clk); #1;
        tests++;
        if ({PCWrite, IRWrite, RegWrite, MemWrite, be} !== 8'h00) begin
            fails++; $display("FAIL rst_enables got %b exp 00000000", {PCWrite, IRWrite, RegWrite, MemWrite, be});
        end
        tests++;
        if ({AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc} !== FETCH_SEL) begin
            fails++; $display("FAIL rst_selects got %b exp %b", {AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc}, FETCH_SEL);
        end
        reset = 1'b0; mN = 0; mZ = 0; mC = 0; mV = 0;
        #1;
        tests++;
        if (IRWrite !== 1'b1) begin fails++; $display("FAIL rst_first_fetch IRWrite got %b exp 1", IRWrite); end

        // CMP forcing Z=1 so the later reset has something to clear
        ins = 32'hE1520003; ff_en = 1; ff_val = 4'b0100;
        predict(ins); exec_instr(ins[31:5], 0, 0, e_len, e_mem); model_update(ins); ff_en = 0;
        tests++;
        if (obs_len !== 3) begin fails++; $display("FAIL rst_cmp_len got %0d exp 3", obs_len); end

        ins = 32'hE5821004;
        Instr = ins[31:5]; MemReady = 1'b1; #1;
        @(negedge clk); MemReady = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        tests++;
        if ({MemWrite, be} !== 5'b1_1111) begin
            fails++; $display("FAIL rst_pre_memwrite got %b exp 11111", {MemWrite, be});
        end
        reset = 1'b1; #1;
        tests++;
        if ({PCWrite, IRWrite, RegWrite, MemWrite, be} !== 8'h00) begin
            fails++; $display("FAIL rst_abort_memwrite got %b exp 00000000", {PCWrite, IRWrite, RegWrite, MemWrite, be});
        end
        @(negedge clk); #1;
        tests++;
        if ({MemWrite, be, AdrSrc} !== 6'b0) begin
            fails++; $display("FAIL rst_hold got %b exp 000000", {MemWrite, be, AdrSrc});
        end
        reset = 1'b0; MemReady = 1'b1; mN = 0; mZ = 0; mC = 0; mV = 0;
        #1;
        tests++;
        if ({PCWrite, IRWrite} !== 2'b11) begin
            fails++; $display("FAIL rst_refetch got %b exp 11", {PCWrite, IRWrite});
        end
        ins = 32'h0A000002;
        predict(ins); exec_instr(ins[31:5], 0, 0, e_len, e_mem); model_update(ins);
        tests++;
        if (obs_len !== 2 || obs_pc_cnt !== 0) begin
            fails++; $display("FAIL rst_flags_cleared beq len %0d pc %0d exp len 2 pc 0", obs_len, obs_pc_cnt);
        end
    endtask

    task automatic test_dp_flags();
        logic [31:0] ins;
        ins = 32'hE2921005; ff_en = 1; ff_val = 4'b0100;
        predict(ins); exec_instr(ins[31:5], 0, 0, e_len, e_mem); model_update(ins); ff_en = 0;
        tests++;
        if (obs_len !== 4) begin fails++; $display("FAIL adds_len got %0d exp 4", obs_len); end
        tests++;
        if (obs_rw_cnt !== 1 || obs_rw_k !== 3 || obs_rw_src !== 2'b00) begin
            fails++; $display("FAIL adds_regwrite cnt %0d k %0d src %b exp 1 3 00", obs_rw_cnt, obs_rw_k, obs_rw_src);
        end
        tests++;
        if (obs_alu2 !== 4'h0 || obs_srcb2 !== 2'b01 || obs_srca2 !== 1'b0) begin
            fails++; $display("FAIL adds_exec_sel alu %b srcb %b srca %b exp 0000 01 0", obs_alu2, obs_srcb2, obs_srca2);
        end
        ins = 32'h0A000002;
        predict(ins); exec_instr(ins[31:5], 0, 0, e_len, e_mem); model_update(ins);
        tests++;
        if (obs_len !== 3 || obs_pc_cnt !== 1) begin
            fails++; $display("FAIL adds_z_beq len %0d pc %0d exp 3 1", obs_len, obs_pc_cnt);
        end
    endtask

    task automatic test_cmp_branch();
        logic [31:0] ins;
        for (int r = 0; r < 2; r++) begin
            ins = 32'hE1520003; ff_en = 1; ff_val = (r == 0) ? 4'b0100 : 4'b0000;
            predict(ins); exec_instr(ins[31:5], 0, 0, e_len, e_mem); model_update(ins); ff_en = 0;
            tests++;
            if (obs_len !== 3 || obs_rw_cnt !== 0) begin
                fails++; $display("FAIL cmp_shape r%0d len %0d rw %0d exp 3 0", r, obs_len, obs_rw_cnt);
            end
            ins = 32'h0A000002;
            predict(ins); exec_instr(ins[31:5], 0, 0, e_len, e_mem); model_update(ins);
            tests++;
            if (r == 0 && (obs_len !== 3 || obs_pc_cnt !== 1 || obs_pc_k !== 2)) begin
                fails++; $display("FAIL beq_taken len %0d pc %0d k %0d exp 3 1 2", obs_len, obs_pc_cnt, obs_pc_k);
            end else if (r == 1 && (obs_len !== 2 || obs_pc_cnt !== 0)) begin
                fails++; $display("FAIL beq_not_taken len %0d pc %0d exp 2 0", obs_len, obs_pc_cnt);
            end
        end
    endtask

    task automatic test_ldr_stall();
        logic [31:0] ins;
        ins = 32'hE5921004;
        predict(ins); exec_instr(ins[31:5], 0, 2, e_len, e_mem); model_update(ins);
        tests++;
        if (obs_len !== 7) begin fails++; $display("FAIL ldr_len got %0d exp 7", obs_len); end
        tests++;
        if (obs_rw_cnt !== 1 || obs_rw_k !== 6 || obs_rw_src !== 2'b01) begin
            fails++; $display("FAIL ldr_wb cnt %0d k %0d src %b exp 1 6 01", obs_rw_cnt, obs_rw_k, obs_rw_src);
        end
    endtask

    task automatic test_store_be();
        logic [31:0] ins;
        ins = 32'hE5C21001; fa_en = 1; fa_val = 2'b10;
        predict(ins); exec_instr(ins[31:5], 0, 0, e_len, e_mem); model_update(ins); fa_en = 0;
        tests++;
        if (obs_len !== 4 || obs_mw_cnt !== 1 || obs_be !== 4'b0100 || obs_be_bad !== 0) begin
            fails++; $display("FAIL strb_be len %0d mw %0d be %b bad %0d exp 4 1 0100 0", obs_len, obs_mw_cnt, obs_be, obs_be_bad);
        end
        ins = 32'hE5821004;
        predict(ins); exec_instr(ins[31:5], 0, 1, e_len, e_mem); model_update(ins);
        tests++;
        if (obs_len !== 5 || obs_mw_cnt !== 2 || obs_be !== 4'b1111 || obs_mw_adrsrc !== 1'b1) begin
            fails++; $display("FAIL str_be len %0d mw %0d be %b adr %b exp 5 2 1111 1", obs_len, obs_mw_cnt, obs_be, obs_mw_adrsrc);
        end
    endtask

    task automatic test_fetch_stall();
        logic [31:0] ins;
        ins = 32'hE0821003;
        predict(ins); exec_instr(ins[31:5], 3, 0, e_len, e_mem); model_update(ins);
        tests++;
        if (obs_stall_bad !== 0) begin fails++; $display("FAIL fetch_stall_strobes got %0d exp 0", obs_stall_bad); end
        tests++;
        if ({obs_f_pc, obs_f_ir} !== 2'b11 || obs_pc_cnt !== 0 || obs_len !== 4) begin
            fails++; $display("FAIL fetch_release pc/ir %b extra_pc %0d len %0d exp 11 0 4", {obs_f_pc, obs_f_ir}, obs_pc_cnt, obs_len);
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        int fs, ms, v;
        for (int i = 0; i < 200; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 2) == 0) ins[31:28] = 4'hE;
            v = $urandom_range(0, 9);
            ins[27:26] = (v < 4) ? 2'b00 : (v < 7) ? 2'b01 : (v < 9) ? 2'b10 : 2'b11;
            if (ins[27:26] == 2'b00) begin
                case ($urandom_range(0, 6))
                    0: ins[24:21] = 4'b0100;
                    1: ins[24:21] = 4'b0010;
                    2: ins[24:21] = 4'b0000;
                    3: ins[24:21] = 4'b1100;
                    4: ins[24:21] = 4'b0001;
                    5: ins[24:21] = 4'b1010;
                    default: ins[24:21] = 4'($urandom);
                endcase
            end
            predict(ins);
            fs = $urandom_range(0, 2);
            ms = e_mem ? $urandom_range(0, 3) : 0;
            exec_instr(ins[31:5], fs, ms, e_len, e_mem);
            model_update(ins);
            tests++;
            if (obs_len !== e_len + ms) begin
                fails++; $display("FAIL rnd_len #%0d ins %08h got %0d exp %0d", i, ins, obs_len, e_len + ms);
            end
            tests++;
            if (obs_rw_cnt !== e_rw || (e_rw == 1 && (obs_rw_k !== e_rw_k + ms || obs_rw_src !== e_rw_src))) begin
                fails++; $display("FAIL rnd_regwrite #%0d ins %08h cnt %0d k %0d src %b exp %0d %0d %b", i, ins, obs_rw_cnt, obs_rw_k, obs_rw_src, e_rw, e_rw_k + ms, e_rw_src);
            end
            tests++;
            if (obs_pc_cnt !== e_pc || (e_pc == 1 && obs_pc_k !== 2)) begin
                fails++; $display("FAIL rnd_pcwrite #%0d ins %08h cnt %0d k %0d exp %0d 2", i, ins, obs_pc_cnt, obs_pc_k, e_pc);
            end
            tests++;
            if (obs_mw_cnt !== (e_mw ? ms + 1 : 0) || obs_be_bad !== 0 ||
                (e_mw == 1 && obs_be !== (ins[22] ? (4'b0001 << obs_be_adr) : 4'b1111))) begin
                fails++; $display("FAIL rnd_store #%0d ins %08h mw %0d be %b adr %0d bad %0d", i, ins, obs_mw_cnt, obs_be, obs_be_adr, obs_be_bad);
            end
            tests++;
            if (obs_f_sel !== FETCH_SEL || {obs_f_pc, obs_f_ir} !== 2'b11 || obs_stall_bad !== 0 || obs_static_bad !== 0) begin
                fails++; $display("FAIL rnd_fetch #%0d ins %08h sel %b pcir %b stall %0d static %0d exp %b 11 0 0", i, ins, obs_f_sel, {obs_f_pc, obs_f_ir}, obs_stall_bad, obs_static_bad, FETCH_SEL);
            end
            if (e_chk2) begin
                tests++;
                if (obs_srca2 !== 1'b0 || obs_srcb2 !== e_srcb || (e_chk_alu && obs_alu2 !== e_alu)) begin
                    fails++; $display("FAIL rnd_exec_sel #%0d ins %08h srca %b srcb %b alu %b exp 0 %b %b", i, ins, obs_srca2, obs_srcb2, obs_alu2, e_srcb, e_alu);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_dp_flags();
        test_cmp_branch();
        test_ldr_stall();
        test_store_be();
        test_fetch_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
